// File: rtl/sae_apb_pkg.sv
// Shared APB master definitions: FSM state encoding and default bus geometry.
package sae_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam int DEF_ADDRESSWIDTH = 3;
  localparam int DEF_DATAWIDTH    = 24;
  localparam int DEF_TIMEOUT      = 16;

endpackage

// File: rtl/apb_master.sv
// APB initiator: turns one request into a SETUP/ACCESS transfer and returns a
// single response, aborting with rsp_timeout if the completer stalls too long.
module apb_master
  import sae_apb_pkg::*;
#(
  parameter int ADDRESSWIDTH = DEF_ADDRESSWIDTH,
  parameter int DATAWIDTH    = DEF_DATAWIDTH,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  // Request/response: a beat transfers on a clock edge where valid and ready are both high.
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDRESSWIDTH-1:0] req_addr,
  input  logic [DATAWIDTH-1:0]    req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATAWIDTH-1:0]    rsp_rdata,
  output logic                    rsp_timeout,
  output logic [ADDRESSWIDTH-1:0] PADDR,
  output logic [DATAWIDTH-1:0]    PWDATA,
  output logic                    PWRITE,
  output logic                    PSELx,
  output logic                    PENABLE,
  input  logic [DATAWIDTH-1:0]    PRDATA,
  input  logic                    PREADY,
  output logic [1:0]              dbg_state
);

  // At least one counter bit even when the timeout is disabled.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  apb_state_e               state_q;
  logic [ADDRESSWIDTH-1:0]  paddr_q;
  logic [DATAWIDTH-1:0]     pwdata_q;
  logic                     pwrite_q;
  logic                     psel_q;
  logic                     penable_q;
  logic                     rsp_valid_q;
  logic [DATAWIDTH-1:0]     rsp_rdata_q;
  logic                     rsp_timeout_q;
  logic [CW-1:0]            cnt_q;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q       <= ST_IDLE;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            pwrite_q <= req_write;
            paddr_q  <= req_addr;
            pwdata_q <= req_wdata;
            psel_q   <= 1'b1;
            state_q  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
            state_q       <= ST_RESP;
          end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
            state_q       <= ST_RESP;
          end else if (cnt_q != CNT_MAX) begin
            // Saturate so a disabled timeout never wraps the counter.
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PWRITE      = pwrite_q;
  assign PSELx       = psel_q;
  assign PENABLE     = penable_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a small register-file completer model.
module tb_apb_master;
  import sae_apb_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_addr;
  logic [23:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [23:0] rsp_rdata;
  logic [2:0]  PADDR;
  logic [23:0] PWDATA, PRDATA;
  logic        PWRITE, PSELx, PENABLE, PREADY;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;
  int n;

  logic [23:0] mem [8] = '{default: 24'h0};

  always #5 PCLK = ~PCLK;

  apb_master #(.ADDRESSWIDTH(3), .DATAWIDTH(24), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSELx(PSELx),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY),
    .dbg_state(dbg_state)
  );

  // Completer register file: commits writes on the completing ACCESS edge.
  always @(posedge PCLK) begin
    if (PSELx && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic wr, input logic [2:0] a, input logic [23:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
  endtask

  initial begin
    PRESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b1;
    tick(); tick();

    check("rst_req_ready", req_ready, 1);
    check("rst_psel", PSELx, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_state", dbg_state, ST_IDLE);
    PRESETn = 1'b1;
    tick();

    // Zero-wait write: SETUP at 1, ACCESS at 2, response at 3.
    drive_req(1'b1, 3'd2, 24'h0000A5);
    check("w_c0_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("w_c1_psel", PSELx, 1);
    check("w_c1_penable", PENABLE, 0);
    check("w_c1_pwrite", PWRITE, 1);
    check("w_c1_paddr", PADDR, 3'd2);
    check("w_c1_pwdata", PWDATA, 24'h0000A5);
    check("w_c1_ready", req_ready, 0);
    tick();
    check("w_c2_psel", PSELx, 1);
    check("w_c2_penable", PENABLE, 1);
    check("w_c2_rsp_valid", rsp_valid, 0);
    tick();
    check("w_c3_rsp_valid", rsp_valid, 1);
    check("w_c3_timeout", rsp_timeout, 0);
    check("w_c3_rdata", rsp_rdata, 0);
    check("w_c3_psel", PSELx, 0);
    check("w_c3_penable", PENABLE, 0);
    check("w_c3_paddr_hold", PADDR, 3'd2);
    check("w_mem2", mem[2], 24'h0000A5);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("w_idle_rsp_valid", rsp_valid, 0);
    check("w_idle_ready", req_ready, 1);

    // Read with three wait states; stale PRDATA must not be captured.
    PREADY = 1'b0;
    PRDATA = 24'hDEAD00;
    drive_req(1'b0, 3'd5, 24'h777777);
    tick();
    req_valid = 1'b0;
    check("r_setup_penable", PENABLE, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("r_acc_penable", PENABLE, 1);
      check("r_acc_paddr", PADDR, 3'd5);
      check("r_acc_pwrite", PWRITE, 0);
      if (i == 3) begin
        PREADY = 1'b1;
        PRDATA = 24'h123456;
      end
      tick();
    end
    PRDATA = 24'h0F0F0F;
    check("r_resp_penable", PENABLE, 0);
    check("r_resp_valid", rsp_valid, 1);
    check("r_resp_rdata", rsp_rdata, 24'h123456);
    check("r_resp_timeout", rsp_timeout, 0);

    // Stalled consumer: response held, competing request refused.
    drive_req(1'b1, 3'd7, 24'hABCDEF);
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rdata", rsp_rdata, 24'h123456);
      check("stall_req_ready", req_ready, 0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("stall_idle_state", dbg_state, ST_IDLE);
    check("stall_not_accepted", PADDR, 3'd5);
    check("stall_mem7", mem[7], 24'h0);

    // Completer never ready: exactly 16 ACCESS cycles then timeout.
    PREADY = 1'b0;
    PRDATA = 24'hFFFFFF;
    drive_req(1'b0, 3'd1, 24'h0);
    tick();
    req_valid = 1'b0;
    tick();
    n = 0;
    while (PENABLE === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check("to_access_cycles", n, 16);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_timeout", rsp_timeout, 1);
    check("to_rdata", rsp_rdata, 0);
    check("to_psel", PSELx, 0);
    check("to_penable", PENABLE, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("to_idle_ready", req_ready, 1);

    // Reset pulse during ACCESS aborts the transfer silently.
    drive_req(1'b1, 3'd3, 24'h333333);
    tick();
    req_valid = 1'b0;
    tick();
    check("rr_in_access", PENABLE, 1);
    PRESETn = 1'b0;
    tick();
    check("rr_psel", PSELx, 0);
    check("rr_penable", PENABLE, 0);
    check("rr_rsp_valid", rsp_valid, 0);
    PRESETn = 1'b1;
    tick();
    check("rr_ready_after", req_ready, 1);
    check("rr_rsp_valid_after", rsp_valid, 0);
    check("rr_mem3", mem[3], 24'h0);

    // Back-to-back writes with request and response always offered.
    PREADY = 1'b1;
    rsp_ready = 1'b1;
    drive_req(1'b1, 3'd4, 24'h111111);
    tick(); tick(); tick();
    check("b2b_rsp1", rsp_valid, 1);
    drive_req(1'b1, 3'd6, 24'h222222);
    tick();
    check("b2b_gap_rsp", rsp_valid, 0);
    check("b2b_gap_idle", dbg_state, ST_IDLE);
    tick();
    req_valid = 1'b0;
    tick(); tick();
    check("b2b_rsp2", rsp_valid, 1);
    tick();
    rsp_ready = 1'b0;
    check("b2b_mem4", mem[4], 24'h111111);
    check("b2b_mem6", mem[6], 24'h222222);
    check("b2b_end_idle", dbg_state, ST_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDRESSWIDTH, default 3, the APB address width.
REQ-002 SHALL have parameter DATAWIDTH, default 24, the APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, the maximum ACCESS cycles without PREADY; a value of 0 disables the timeout.
REQ-004 SHALL use one clock, PCLK; reset is synchronous and active-low, PRESETn.
REQ-005 PCLK  input  1  system and APB clock.
REQ-006 PRESETn  input  1  synchronous active-low reset.
REQ-007 req_valid  input  1  transfer request present.
REQ-008 req_ready  output  1  request accepted when high together with req_valid.
REQ-009 req_write  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDRESSWIDTH  transfer address.
REQ-011 req_wdata  input  DATAWIDTH  write data.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-014 rsp_rdata  output  DATAWIDTH  read data; 0 for writes and timeouts.
REQ-015 rsp_timeout  output  1  transfer aborted by timeout.
REQ-016 PADDR, PWDATA, PWRITE, PSELx, PENABLE  output  ADDRESSWIDTH/DATAWIDTH/1/1/1  APB initiator signals.
REQ-017 PRDATA  input  DATAWIDTH  and PREADY  input  1  APB completer signals.

Function
REQ-018 The FSM SHALL have four states: IDLE, SETUP, ACCESS, RESP.
REQ-019 IDLE: req_ready = 1; on req_valid, capture write/addr/wdata and go to SETUP.
REQ-020 SETUP: PSELx = 1 and PENABLE = 0 for exactly one cycle, then go to ACCESS.
REQ-021 ACCESS: PSELx = 1 and PENABLE = 1 until PREADY = 1 or timeout.
REQ-022 ACCESS with PREADY = 1: latch PRDATA into rsp_rdata (reads only), clear rsp_timeout, go to RESP.
REQ-023 ACCESS wait counter: cleared on entry and incremented each cycle PREADY = 0.
REQ-024 Timeout: if TIMEOUT != 0 and the counter reaches TIMEOUT-1 with PREADY = 0, go to RESP with rsp_timeout = 1 and rsp_rdata = 0.
REQ-025 Timeout counter width SHALL be clog2(TIMEOUT+1) bits and SHALL never wrap.
REQ-026 RESP: rsp_valid = 1; rsp_rdata and rsp_timeout are held stable; on rsp_ready go to IDLE.
REQ-027 req_ready SHALL be 0 in SETUP, ACCESS and RESP; no request is queued.
REQ-028 PADDR, PWRITE and PWDATA SHALL be stable from SETUP through the last ACCESS cycle and SHALL hold their last values in IDLE and RESP.
REQ-029 PSELx and PENABLE SHALL be 0 in IDLE and RESP.
REQ-030 Minimum latency: request accepted at cycle 0 gives SETUP at cycle 1, ACCESS at cycle 2, and rsp_valid at cycle 3 when PREADY = 1.
REQ-031 Back-to-back transfers SHALL include at least one IDLE cycle between responses.
REQ-032 PREADY SHALL be ignored outside ACCESS.

Reset
REQ-033 On a PCLK edge with PRESETn = 0: state = IDLE, and PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_timeout and the counter all = 0.
REQ-034 Reset mid-transfer SHALL abort it with no response; req_ready = 1 on the first cycle after PRESETn returns high.

Structure
REQ-035 Shared package sae_apb_pkg SHALL hold the FSM state typedef and the default ADDRESSWIDTH/DATAWIDTH/TIMEOUT constants.
REQ-036 The design SHALL be a single module with no sub-module; the counter is inline.

Verification
REQ-037 Write addr 3'd2, data 24'h0000A5, PREADY tied 1 -> PSELx at cycle 1, PENABLE at cycle 2, PWRITE = 1, rsp_valid at cycle 3, rsp_timeout = 0, rsp_rdata = 0.
REQ-038 Read addr 3'd5, PREADY low for 3 ACCESS cycles then high with PRDATA = 24'h123456 -> PENABLE high 4 cycles, PADDR stable, rsp_rdata = 24'h123456.
REQ-039 TIMEOUT = 16, PREADY never high -> exactly 16 ACCESS cycles, then rsp_valid with rsp_timeout = 1, rsp_rdata = 0, and PSELx/PENABLE = 0.
REQ-040 rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable throughout, req_ready = 0, competing req_valid not accepted.
REQ-041 PRESETn low for 1 cycle during ACCESS -> next edge PSELx = 0, PENABLE = 0, rsp_valid = 0; req_ready = 1 the cycle after release.
REQ-042 Two consecutive writes against an apb_slave instance -> both reach the slave registers and are separated by at least 1 IDLE cycle.
